// File: rtl/isa_pkg.sv
// Shared ISA table for the instruction encoder/loader and the opcode decoder:
// opcode values, request kinds and loader error codes.
package isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [2:0] {
    KIND_R    = 3'd0,
    KIND_LW   = 3'd1,
    KIND_SW   = 3'd2,
    KIND_BNE  = 3'd3,
    KIND_XORI = 3'd4,
    KIND_J    = 3'd5
  } kind_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_ILLEGAL = 2'b01,
    ERR_FULL    = 2'b10
  } err_code_e;

  function automatic logic [31:0] pack_itype(input logic [5:0] op, input logic [4:0] rs,
                                             input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: request kind plus fields -> legality flag and 32-bit MIPS word.
module instr_pack
  import isa_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic        legal,
  output logic [31:0] word
);

  always_comb begin
    legal = 1'b1;
    word  = '0;
    case (kind)
      KIND_R:    word = {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
      KIND_LW:   word = pack_itype(OP_LW, rs, rt, imm);
      KIND_SW:   word = pack_itype(OP_SW, rs, rt, imm);
      KIND_BNE:  word = pack_itype(OP_BNE, rs, rt, imm);
      KIND_XORI: word = pack_itype(OP_XORI, rs, rt, imm);
      KIND_J:    word = {OP_J, target};
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Accepts symbolic instruction requests, encodes them and writes them sequentially
// into instruction memory starting at BASE_ADDR, one registered write per legal request.
module instr_encoder_loader
  import isa_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_kind,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [5:0]        req_funct,
  input  logic [15:0]       req_imm,
  input  logic [25:0]       req_target,
  input  logic              req_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_e;

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   LAST_SLOT = {1'b0, {ADDR_W{1'b1}}};

  state_e            state, state_nx;
  err_code_e         ec_q, ec_nx;
  logic [ADDR_W-1:0] ptr;
  logic              legal;
  logic [31:0]       word;
  logic              accept;
  logic              arm;

  instr_pack u_pack (
    .kind   (req_kind),
    .rs     (req_rs),
    .rt     (req_rt),
    .rd     (req_rd),
    .funct  (req_funct),
    .imm    (req_imm),
    .target (req_target),
    .legal  (legal),
    .word   (word)
  );

  assign req_ready = (state == S_LOAD);
  assign accept    = req_valid & req_ready;
  assign arm       = start & (state != S_LOAD);
  assign busy      = (state == S_LOAD);
  assign done      = (state == S_DONE);
  assign err       = (state == S_ERR);
  assign err_code  = ec_q;

  always_comb begin
    state_nx = state;
    ec_nx    = ec_q;
    case (state)
      S_LOAD: begin
        if (accept) begin
          // last wins over full so an exact-fit program still ends in DONE
          if (!legal) begin
            state_nx = S_ERR;
            ec_nx    = ERR_ILLEGAL;
          end else if (req_last) begin
            state_nx = S_DONE;
          end else if (count == LAST_SLOT) begin
            state_nx = S_ERR;
            ec_nx    = ERR_FULL;
          end
        end
      end
      default: begin
        if (start) begin
          state_nx = S_LOAD;
          ec_nx    = ERR_NONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      ec_q  <= ERR_NONE;
    end else begin
      state <= state_nx;
      ec_q  <= ec_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= BASE;
      count     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= BASE;
      mem_wdata <= '0;
    end else begin
      mem_we <= accept & legal;
      if (arm) begin
        ptr   <= BASE;
        count <= '0;
      end else if (accept && legal) begin
        ptr       <= ptr + 1'b1;
        count     <= count + 1'b1;
        mem_addr  <= ptr;
        mem_wdata <= word;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: a 256-word and a 4-word instance share one stimulus
// stream and are compared every cycle against a transaction-level reference model.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        reset, start, req_valid, req_last;
  logic [2:0]  req_kind;
  logic [4:0]  req_rs, req_rt, req_rd;
  logic [5:0]  req_funct;
  logic [15:0] req_imm;
  logic [25:0] req_target;

  logic        b_ready, b_we, b_busy, b_done, b_err;
  logic [7:0]  b_addr;
  logic [31:0] b_wdata;
  logic [1:0]  b_ec;
  logic [8:0]  b_count;

  logic        s_ready, s_we, s_busy, s_done, s_err;
  logic [1:0]  s_addr;
  logic [31:0] s_wdata;
  logic [1:0]  s_ec;
  logic [2:0]  s_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) u_big (
    .clk(clk), .reset(reset), .start(start), .req_valid(req_valid), .req_ready(b_ready),
    .req_kind(req_kind), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_funct(req_funct), .req_imm(req_imm), .req_target(req_target), .req_last(req_last),
    .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata), .busy(b_busy), .done(b_done),
    .err(b_err), .err_code(b_ec), .count(b_count)
  );

  instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) u_small (
    .clk(clk), .reset(reset), .start(start), .req_valid(req_valid), .req_ready(s_ready),
    .req_kind(req_kind), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_funct(req_funct), .req_imm(req_imm), .req_target(req_target), .req_last(req_last),
    .mem_we(s_we), .mem_addr(s_addr), .mem_wdata(s_wdata), .busy(s_busy), .done(s_done),
    .err(s_err), .err_code(s_ec), .count(s_count)
  );

  // Reference model: session mode 0 idle, 1 loading, 2 done, 3 error
  localparam int M_IDLE = 0, M_LOAD = 1, M_DONE = 2, M_ERR = 3;
  int          depth [2] = '{256, 4};
  int          m_mode[2], m_ptr[2], m_cnt[2], m_ec[2];
  bit          m_we  [2];
  int          m_addr[2];
  logic [31:0] m_wd  [2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_encode(input int k, input int rs, input int rt, input int rd,
                                              input int funct, input int imm, input int target);
    longint opv, w;
    case (k)
      0: opv = 0;
      1: opv = 35;
      2: opv = 43;
      3: opv = 5;
      4: opv = 14;
      default: opv = 2;
    endcase
    if (k == 0)      w = longint'(rs) * 2097152 + rt * 65536 + rd * 2048 + funct;
    else if (k == 5) w = opv * 67108864 + target;
    else             w = opv * 67108864 + longint'(rs) * 2097152 + rt * 65536 + imm;
    return w[31:0];
  endfunction

  task automatic model_reset_all();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = M_IDLE; m_ptr[i] = 0; m_cnt[i] = 0; m_ec[i] = 0;
      m_we[i] = 1'b0; m_addr[i] = 0; m_wd[i] = '0;
    end
  endtask

  task automatic model_step();
    int k;
    k = int'(req_kind);
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_mode[i] = M_IDLE; m_ptr[i] = 0; m_cnt[i] = 0; m_ec[i] = 0;
        m_we[i] = 1'b0; m_addr[i] = 0; m_wd[i] = '0;
      end else begin
        m_we[i] = 1'b0;
        if (m_mode[i] != M_LOAD) begin
          if (start) begin
            m_mode[i] = M_LOAD; m_cnt[i] = 0; m_ptr[i] = 0; m_ec[i] = 0;
          end
        end else if (req_valid) begin
          if (k > 5) begin
            m_mode[i] = M_ERR; m_ec[i] = 1;
          end else begin
            m_we[i]   = 1'b1;
            m_addr[i] = m_ptr[i];
            m_wd[i]   = ref_encode(k, int'(req_rs), int'(req_rt), int'(req_rd),
                                   int'(req_funct), int'(req_imm), int'(req_target));
            m_ptr[i]  = (m_ptr[i] + 1) % depth[i];
            m_cnt[i]  = m_cnt[i] + 1;
            if (req_last) m_mode[i] = M_DONE;
            else if (m_cnt[i] == depth[i]) begin
              m_mode[i] = M_ERR; m_ec[i] = 2;
            end
          end
        end
      end
    end
  endtask

  task automatic compare_dut(input int i, input logic rdy, input logic we, input logic [31:0] addr,
                             input logic [31:0] wd, input logic bsy, input logic dn, input logic er,
                             input logic [1:0] ec, input logic [31:0] cnt);
    check_eq($sformatf("u%0d.req_ready", i), 32'(rdy), 32'(m_mode[i] == M_LOAD));
    check_eq($sformatf("u%0d.mem_we", i), 32'(we), 32'(m_we[i]));
    check_eq($sformatf("u%0d.mem_addr", i), addr, 32'(m_addr[i]));
    check_eq($sformatf("u%0d.mem_wdata", i), wd, m_wd[i]);
    check_eq($sformatf("u%0d.busy", i), 32'(bsy), 32'(m_mode[i] == M_LOAD));
    check_eq($sformatf("u%0d.done", i), 32'(dn), 32'(m_mode[i] == M_DONE));
    check_eq($sformatf("u%0d.err", i), 32'(er), 32'(m_mode[i] == M_ERR));
    check_eq($sformatf("u%0d.err_code", i), 32'(ec), 32'(m_ec[i]));
    check_eq($sformatf("u%0d.count", i), cnt, 32'(m_cnt[i]));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_dut(0, b_ready, b_we, 32'(b_addr), b_wdata, b_busy, b_done, b_err, b_ec, 32'(b_count));
    compare_dut(1, s_ready, s_we, 32'(s_addr), s_wdata, s_busy, s_done, s_err, s_ec, 32'(s_count));
  endtask

  task automatic idle_inputs();
    reset = 1'b0; start = 1'b0; req_valid = 1'b0; req_last = 1'b0; req_kind = '0;
    req_rs = '0; req_rt = '0; req_rd = '0; req_funct = '0; req_imm = '0; req_target = '0;
  endtask

  task automatic do_start();
    idle_inputs();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic req(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic [5:0] fn, input logic [15:0] imm,
                     input logic [25:0] tgt, input logic last);
    req_valid = 1'b1; req_kind = k; req_rs = rs; req_rt = rt; req_rd = rd;
    req_funct = fn; req_imm = imm; req_target = tgt; req_last = last;
    cyc();
  endtask

  initial begin
    model_reset_all();
    idle_inputs();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();

    // single LW with last
    do_start();
    req(3'd1, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0004, 26'd0, 1'b1);
    check_eq("lw_word", b_wdata, 32'h8C220004);
    check_eq("lw_done", 32'(b_done), 32'd1);
    req_valid = 1'b0;
    cyc();

    // back-to-back R, SW, J(last)
    do_start();
    req(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0000, 26'd0, 1'b0);
    check_eq("r_word", b_wdata, 32'h00221820);
    req(3'd2, 5'd29, 5'd31, 5'd0, 6'd0, 16'h0008, 26'd0, 1'b0);
    check_eq("sw_word", b_wdata, 32'hAFBF0008);
    req(3'd5, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0000, 26'h10, 1'b1);
    check_eq("j_word", b_wdata, 32'h08000010);
    check_eq("j_addr", 32'(b_addr), 32'd2);
    req_valid = 1'b0;
    cyc();

    // XORI / BNE immediates packed without sign extension
    do_start();
    req(3'd4, 5'd4, 5'd5, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b0);
    check_eq("xori_word", b_wdata, 32'h3885FFFF);
    req(3'd3, 5'd1, 5'd2, 5'd0, 6'd0, 16'hFFFE, 26'd0, 1'b1);
    check_eq("bne_word", b_wdata, 32'h1422FFFE);
    req_valid = 1'b0;
    cyc();

    // illegal kind after two legal words
    do_start();
    req(3'd1, 5'd3, 5'd4, 5'd0, 6'd0, 16'h0010, 26'd0, 1'b0);
    req(3'd1, 5'd3, 5'd5, 5'd0, 6'd0, 16'h0014, 26'd0, 1'b0);
    req(3'd6, 5'd3, 5'd5, 5'd0, 6'd0, 16'h0018, 26'd0, 1'b0);
    check_eq("illegal_code", 32'(b_ec), 32'd1);
    check_eq("illegal_cnt", 32'(b_count), 32'd2);
    req_valid = 1'b0;
    cyc();

    // fill the 4-word instance: overflow, then exact fit
    do_start();
    for (int n = 0; n < 4; n++) req(3'd0, 5'(n), 5'd1, 5'd2, 6'h21, 16'h0, 26'd0, 1'b0);
    check_eq("full_code", 32'(s_ec), 32'd2);
    do_start();
    for (int n = 0; n < 4; n++) req(3'd0, 5'(n), 5'd1, 5'd2, 6'h21, 16'h0, 26'd0, n == 3);
    check_eq("exact_fit_done", 32'(s_done), 32'd1);
    req_valid = 1'b0;
    cyc();

    // reset mid-stream with req_valid held
    do_start();
    req(3'd2, 5'd7, 5'd8, 5'd0, 6'd0, 16'h0100, 26'd0, 1'b0);
    req(3'd2, 5'd7, 5'd9, 5'd0, 6'd0, 16'h0104, 26'd0, 1'b0);
    reset = 1'b1;
    cyc();
    check_eq("reset_we", 32'(b_we), 32'd0);
    reset = 1'b0;
    cyc();
    cyc();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      reset      = ($urandom_range(0, 199) == 0);
      start      = ($urandom_range(0, 9) == 0);
      req_valid  = ($urandom_range(0, 3) != 0);
      r          = $urandom_range(0, 19);
      req_kind   = (r < 18) ? 3'(r % 6) : 3'(r - 12);
      req_last   = ($urandom_range(0, 15) == 0);
      req_rs     = 5'($urandom);
      req_rt     = 5'($urandom);
      req_rd     = 5'($urandom);
      req_funct  = 6'($urandom);
      req_imm    = 16'($urandom);
      req_target = 26'($urandom);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
